instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage of the Kabeta Beta core, directly upstream of the instruction memory. Maintains the 32-bit PC (bit 31 = supervisor), selects the next fetch address, drives the memory I-port (`Addr_I`, `En_I`), and pairs the returned `Data_I` with its PC for the decode stage. Handles pipeline stall, branch/jump redirect, the illegal-op trap, and interrupt entry, including the Beta supervisor-bit rules.

## Interface
- `RESET_VEC`, 32'h8000_0000, PC after reset.
- `ILLOP_VEC`, 32'h8000_0004, illegal-op trap target.
- `XADR_VEC`, 32'h8000_0008, interrupt target.
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `Stall`  in  1  decode cannot accept; hold current fetch.
- `Redirect`  in  1  taken branch/JMP from execute.
- `Redirect_Target`  in  32  branch/JMP byte address.
- `Illop`  in  1  illegal opcode detected downstream.
- `Irq`  in  1  interrupt request, level.
- `Addr_I`  out  29  I-port word address (`NPC[30:2]`).
- `En_I`  out  1  I-port read enable.
- `Data_I`  in  32  I-port read data, 1-cycle latency.
- `IF_PC`  out  32  PC of `IF_Instr`.
- `IF_Instr`  out  32  fetched instruction (`Data_I` pass-through).
- `IF_Valid`  out  1  `IF_PC`/`IF_Instr` valid for decode.
- `IF_Irq`  out  1  slot replaced by interrupt entry; decode saves `IF_PC`+4 in XP.

## Operation
- State `S_RESET` (no data in flight) → `S_RUN` after the first enabled fetch. Never returns except via reset.
- Registers: `PC_F` (address whose data is on `Data_I`), `Valid_F`, `Irq_F`.
- `NPC` priority, highest first:
  - `S_RESET`: `RESET_VEC`.
  - `Illop`: `ILLOP_VEC`.
  - `Redirect`: `{Redirect_Target[31] & PC_F[31], Redirect_Target[30:2], 2'b00}`. A JMP never gains supervisor mode.
  - Interrupt taken: `XADR_VEC`. Taken when `Irq & Valid_F & ~PC_F[31] & ~Stall`.
  - `Stall`: hold.
  - Otherwise: `{PC_F[31], PC_F[30:2]+1, 2'b00}`. Increment wraps within bits 30:2, and bit 31 is preserved.
- `En_I` = 1 unless holding, i.e. `Stall` with no `Illop`/`Redirect`. When `En_I`=0 the RAM holds `q`, so `Data_I` is stable.
- On `En_I`: `PC_F`←`NPC`, `Valid_F`←1.
- Flush = `Illop | Redirect`. `IF_Valid = Valid_F & ~Flush`.
- Interrupt taken: `IF_Irq`=1 and `IF_Valid`=1 for the interrupted slot. Decode discards `IF_Instr` and forms XP = `IF_PC`+4. `IF_Irq` is combinational.
- `Irq` is ignored in supervisor mode (`PC_F[31]`=1), while stalled, and when `Illop`/`Redirect` is asserted.

## Timing
- While `Reset`=0: `S_RESET`, `PC_F`=`RESET_VEC`, `Valid_F`=0, `En_I`=0, `IF_Valid`=0, `IF_Irq`=0, `Addr_I`=`RESET_VEC[30:2]`.
- First cycle after release: `En_I`=1, `Addr_I`=0x0000000. Next cycle: `IF_Valid`=1, `IF_PC`=0x80000000.
- Steady state: one instruction per cycle. `Addr_I` is driven in cycle n, and the corresponding `IF_Instr` appears in cycle n+1.
- Redirect/Illop in cycle n: the slot in cycle n is squashed, and the target instruction is valid in cycle n+1. Both override `Stall`.
- Stall: `IF_*` outputs are held bit-identical for every stalled cycle. Fetch resumes on the first cycle with `Stall`=0.
- Reset asserted mid-operation: all outputs and state return to reset values asynchronously. In-flight data is discarded.

## Structure
- The shared package `kabeta_pkg` holds the `RESET_VEC`/`ILLOP_VEC`/`XADR_VEC` defaults, the supervisor bit index (31), and the `S_RESET`/`S_RUN` encoding.
- Sub-module `pc_next_select`: combinational priority mux plus incrementer and supervisor masking. Registers stay in `instruction_fetch`.

## Test plan
- Release reset, no stall, memory word i = i → `Addr_I` 0,1,2…; `IF_PC` 0x80000000, 0x80000004…; `IF_Instr` 0,1,2…
- `Stall` for 3 cycles at `IF_PC`=0x80000008 → `En_I`=0; `IF_PC`/`IF_Instr` constant. The next cycle after release shows 0x8000000C.
- `Redirect` with target 0x80001000 while `PC_F`=0x00000010 → `IF_Valid`=0 that cycle; next `IF_PC`=0x00001000.
- `Redirect` and `Illop` with `Stall`=1 in the same cycle → next `IF_PC`=0x80000004 (Illop wins over Redirect and Stall).
- `Irq`=1 in user mode at `IF_PC`=0x00000020 → `IF_Irq`=1 that cycle; next `IF_PC`=0x80000008. With `Irq` held in supervisor mode, `IF_Irq` stays 0.
- PC at 0x7FFFFFFC, sequential → next `IF_PC`=0x00000000 (wrap; bit 31 stays 0). Assert `Reset` mid-stream → `IF_Valid`=0 and `En_I`=0 immediately.

Source files
------------

// File: rtl/kabeta_pkg.sv
// Shared constants for the Kabeta Beta core front end: trap/reset vectors,
// supervisor bit position and the fetch-stage state encoding.
package kabeta_pkg;

    localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC_DEF = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC_DEF  = 32'h8000_0008;

    // PC bit 31 marks supervisor mode
    localparam int unsigned SUPER_BIT = 31;

    // Fetch-stage states: nothing in flight yet / steady running
    localparam logic [0:0] S_RESET = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

endpackage

// File: rtl/instruction_fetch_pc_next_select.sv
// Next-fetch-address selection for the instruction fetch stage: priority mux
// over reset, illegal-op trap, redirect, interrupt entry, stall hold and the
// sequential increment, with the Beta supervisor-bit rules applied.
module pc_next_select
    import kabeta_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
    parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF
) (
    input  logic        in_reset,
    input  logic        illop,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        irq_take,
    input  logic        stall,
    input  logic [31:0] pc_f,
    output logic [31:0] npc,
    output logic        hold
);

    // Byte-offset bits are always zero in a word-aligned fetch address
    logic unused_bits;
    assign unused_bits = ^{redirect_target[1:0], pc_f[1:0]};

    // Only a stall that is not overridden by a flush holds the fetch
    assign hold = stall & ~illop & ~redirect;

    // Priority selection of the next fetch address
    always_comb begin
        npc = pc_f;
        if (in_reset) begin
            npc = RESET_VEC;
        end else if (illop) begin
            npc = ILLOP_VEC;
        end else if (redirect) begin
            // A JMP can drop supervisor mode but never gain it
            npc = {redirect_target[SUPER_BIT] & pc_f[SUPER_BIT],
                   redirect_target[30:2], 2'b00};
        end else if (irq_take) begin
            npc = XADR_VEC;
        end else if (stall) begin
            npc = pc_f;
        end else begin
            // Increment wraps inside bits 30:2; mode bit is untouched
            npc = {pc_f[SUPER_BIT], pc_f[30:2] + 29'd1, 2'b00};
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage of the Kabeta Beta core. Holds the fetch PC, drives
// the instruction-memory read port and pairs returned data with its PC.
module instruction_fetch
    import kabeta_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
    parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] Redirect_Target,
    input  logic        Illop,
    input  logic        Irq,
    output logic [28:0] Addr_I,
    output logic        En_I,
    input  logic [31:0] Data_I,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_Instr,
    output logic        IF_Valid,
    output logic        IF_Irq
);

    logic [0:0]  state;
    logic [31:0] pc_f;
    logic        valid_f;
    logic [31:0] npc;
    logic        hold;
    logic        flush;
    logic        irq_take;

    assign flush    = Illop | Redirect;
    assign irq_take = Irq & valid_f & ~pc_f[SUPER_BIT] & ~Stall & ~flush;

    pc_next_select #(
        .RESET_VEC (RESET_VEC),
        .ILLOP_VEC (ILLOP_VEC),
        .XADR_VEC  (XADR_VEC)
    ) u_pc_next_select (
        .in_reset        (state == S_RESET),
        .illop           (Illop),
        .redirect        (Redirect),
        .redirect_target (Redirect_Target),
        .irq_take        (irq_take),
        .stall           (Stall),
        .pc_f            (pc_f),
        .npc             (npc),
        .hold            (hold)
    );

    // Gating with Reset keeps the memory port idle while reset is held
    assign En_I   = Reset & ~hold;
    assign Addr_I = npc[30:2];

    // Fetch PC, valid flag and state advance on every enabled fetch
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= S_RESET;
            pc_f    <= RESET_VEC;
            valid_f <= 1'b0;
        end else if (!hold) begin
            state   <= S_RUN;
            pc_f    <= npc;
            valid_f <= 1'b1;
        end
    end

    assign IF_PC    = pc_f;
    assign IF_Instr = Data_I;
    assign IF_Valid = valid_f & ~flush;
    assign IF_Irq   = irq_take;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. A one-cycle-latency memory model
// returns the word address as data; expected decode-side slots are queued when
// stimulus is driven and compared the following cycle.
module tb_instruction_fetch;

    logic        Clock;
    logic        Reset;
    logic        Stall;
    logic        Redirect;
    logic [31:0] Redirect_Target;
    logic        Illop;
    logic        Irq;
    logic [28:0] Addr_I;
    logic        En_I;
    logic [31:0] Data_I;
    logic [31:0] IF_PC;
    logic [31:0] IF_Instr;
    logic        IF_Valid;
    logic        IF_Irq;

    typedef struct packed {
        logic        valid;
        logic        irq;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    logic [31:0] mem_q;

    instruction_fetch dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Stall           (Stall),
        .Redirect        (Redirect),
        .Redirect_Target (Redirect_Target),
        .Illop           (Illop),
        .Irq             (Irq),
        .Addr_I          (Addr_I),
        .En_I            (En_I),
        .Data_I          (Data_I),
        .IF_PC           (IF_PC),
        .IF_Instr        (IF_Instr),
        .IF_Valid        (IF_Valid),
        .IF_Irq          (IF_Irq)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Memory word i holds value i; output register only updates when enabled
    initial mem_q = '0;
    always @(posedge Clock) if (En_I) mem_q <= {3'b000, Addr_I};
    assign Data_I = mem_q;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0; Illop = 1'b0; Irq = 1'b0;
        Redirect_Target = '0;
        @(negedge Clock); @(negedge Clock); #1;
        checks++;
        if ({En_I, IF_Valid, IF_Irq} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got en=%b valid=%b irq=%b, want 0 0 0", En_I, IF_Valid, IF_Irq);
        end
        checks++;
        if (Addr_I !== 29'h0 || IF_PC !== 32'h8000_0000) begin
            errors++;
            $display("FAIL reset_addr: got addr=%h pc=%h, want 00000000 80000000", Addr_I, IF_PC);
        end
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        checks++;
        if ({En_I, IF_Valid} !== 2'b10 || Addr_I !== 29'h0) begin
            errors++;
            $display("FAIL first_fetch: got en=%b valid=%b addr=%h, want 1 0 00000000", En_I, IF_Valid, Addr_I);
        end
        sb.push_back('{valid: 1'b1, irq: 1'b0, pc: 32'h8000_0000});
        @(negedge Clock);
    endtask

    task automatic test_sequential();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            Stall = 1'b0; Redirect = 1'b0; Illop = 1'b0; Irq = 1'b0;
            #1;
            e = sb.pop_front();
            checks++;
            if ({IF_Valid, IF_Irq, IF_PC} !== {e.valid, e.irq, e.pc} || IF_Instr !== {3'b000, e.pc[30:2]}) begin
                errors++;
                $display("FAIL seq_slot%0d: got v=%b irq=%b pc=%h instr=%h, want v=%b irq=%b pc=%h instr=%h",
                         i, IF_Valid, IF_Irq, IF_PC, IF_Instr, e.valid, e.irq, e.pc, {3'b000, e.pc[30:2]});
            end
            checks++;
            if (En_I !== 1'b1 || Addr_I !== 29'(i + 1)) begin
                errors++;
                $display("FAIL seq_addr%0d: got en=%b addr=%h, want 1 %h", i, En_I, Addr_I, 29'(i + 1));
            end
            sb.push_back('{valid: 1'b1, irq: 1'b0, pc: e.pc + 32'd4});
            @(negedge Clock);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            Stall = (i < 3);
            #1;
            e = sb.pop_front();
            checks++;
            if ({IF_Valid, IF_Irq, IF_PC} !== {e.valid, e.irq, e.pc} || IF_Instr !== {3'b000, e.pc[30:2]}) begin
                errors++;
                $display("FAIL stall_slot%0d: got v=%b irq=%b pc=%h instr=%h, want v=%b irq=%b pc=%h instr=%h",
                         i, IF_Valid, IF_Irq, IF_PC, IF_Instr, e.valid, e.irq, e.pc, {3'b000, e.pc[30:2]});
            end
            checks++;
            if (En_I !== !Stall) begin
                errors++;
                $display("FAIL stall_en%0d: got en=%b, want %b", i, En_I, !Stall);
            end
            sb.push_back('{valid: 1'b1, irq: 1'b0, pc: Stall ? e.pc : e.pc + 32'd4});
            @(negedge Clock);
        end
        Stall = 1'b0;
    endtask

    task automatic test_redirect();
        exp_t e;
        logic [31:0] tgt [2];
        logic [31:0] nxt [2];
        tgt[0] = 32'h0000_0010; nxt[0] = 32'h0000_0010;
        tgt[1] = 32'h8000_1000; nxt[1] = 32'h0000_1000;
        for (int i = 0; i < 2; i++) begin
            Redirect = 1'b1; Redirect_Target = tgt[i];
            #1;
            e = sb.pop_front();
            e.valid = 1'b0;
            checks++;
            if ({IF_Valid, IF_Irq, IF_PC} !== {e.valid, e.irq, e.pc} || IF_Instr !== {3'b000, e.pc[30:2]}) begin
                errors++;
                $display("FAIL redir_slot%0d: got v=%b irq=%b pc=%h instr=%h, want v=%b irq=%b pc=%h instr=%h",
                         i, IF_Valid, IF_Irq, IF_PC, IF_Instr, e.valid, e.irq, e.pc, {3'b000, e.pc[30:2]});
            end
            checks++;
            if (Addr_I !== nxt[i][30:2]) begin
                errors++;
                $display("FAIL redir_addr%0d: got addr=%h, want %h", i, Addr_I, nxt[i][30:2]);
            end
            sb.push_back('{valid: 1'b1, irq: 1'b0, pc: nxt[i]});
            @(negedge Clock);
        end
        Redirect = 1'b0;
    endtask

    task automatic test_illop_priority();
        exp_t e;
        Stall = 1'b1; Redirect = 1'b1; Redirect_Target = 32'h0000_2000; Illop = 1'b1;
        #1;
        e = sb.pop_front();
        e.valid = 1'b0;
        checks++;
        if ({IF_Valid, IF_Irq, IF_PC} !== {e.valid, e.irq, e.pc} || IF_Instr !== {3'b000, e.pc[30:2]}) begin
            errors++;
            $display("FAIL illop_slot: got v=%b irq=%b pc=%h instr=%h, want v=%b irq=%b pc=%h instr=%h",
                     IF_Valid, IF_Irq, IF_PC, IF_Instr, e.valid, e.irq, e.pc, {3'b000, e.pc[30:2]});
        end
        checks++;
        if (En_I !== 1'b1 || Addr_I !== 29'h1) begin
            errors++;
            $display("FAIL illop_addr: got en=%b addr=%h, want 1 00000001", En_I, Addr_I);
        end
        sb.push_back('{valid: 1'b1, irq: 1'b0, pc: 32'h8000_0004});
        @(negedge Clock);
        Stall = 1'b0; Redirect = 1'b0; Illop = 1'b0;
    endtask

    task automatic test_irq();
        exp_t e;
        logic [4:0]  stall_v = 5'b00100;
        logic [4:0]  redir_v = 5'b00010;
        logic [4:0]  valid_v = 5'b11101;
        logic [4:0]  irq_v   = 5'b01000;
        logic [31:0] nxt [5];
        nxt[0] = 32'h8000_0008; nxt[1] = 32'h0000_0020; nxt[2] = 32'h0000_0020;
        nxt[3] = 32'h8000_0008; nxt[4] = 32'h8000_000C;
        Redirect_Target = 32'h0000_0020;
        for (int i = 0; i < 5; i++) begin
            Irq = 1'b1; Stall = stall_v[i]; Redirect = redir_v[i];
            #1;
            e = sb.pop_front();
            e.valid = valid_v[i];
            e.irq   = irq_v[i];
            checks++;
            if ({IF_Valid, IF_Irq, IF_PC} !== {e.valid, e.irq, e.pc} || IF_Instr !== {3'b000, e.pc[30:2]}) begin
                errors++;
                $display("FAIL irq_slot%0d: got v=%b irq=%b pc=%h instr=%h, want v=%b irq=%b pc=%h instr=%h",
                         i, IF_Valid, IF_Irq, IF_PC, IF_Instr, e.valid, e.irq, e.pc, {3'b000, e.pc[30:2]});
            end
            sb.push_back('{valid: 1'b1, irq: 1'b0, pc: nxt[i]});
            @(negedge Clock);
        end
        Irq = 1'b0; Stall = 1'b0; Redirect = 1'b0;
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [31:0] nxt [3];
        nxt[0] = 32'h7FFF_FFFC; nxt[1] = 32'h0000_0000; nxt[2] = 32'h0000_0004;
        Redirect_Target = 32'h7FFF_FFFC;
        for (int i = 0; i < 3; i++) begin
            Redirect = (i == 0);
            #1;
            e = sb.pop_front();
            e.valid = (i != 0);
            checks++;
            if ({IF_Valid, IF_Irq, IF_PC} !== {e.valid, e.irq, e.pc} || IF_Instr !== {3'b000, e.pc[30:2]}) begin
                errors++;
                $display("FAIL wrap_slot%0d: got v=%b irq=%b pc=%h instr=%h, want v=%b irq=%b pc=%h instr=%h",
                         i, IF_Valid, IF_Irq, IF_PC, IF_Instr, e.valid, e.irq, e.pc, {3'b000, e.pc[30:2]});
            end
            checks++;
            if (Addr_I !== nxt[i][30:2]) begin
                errors++;
                $display("FAIL wrap_addr%0d: got addr=%h, want %h", i, Addr_I, nxt[i][30:2]);
            end
            sb.push_back('{valid: 1'b1, irq: 1'b0, pc: nxt[i]});
            @(negedge Clock);
        end
        Redirect = 1'b0;
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        #3;
        Reset = 1'b0;
        #1;
        checks++;
        if ({IF_Valid, En_I, IF_Irq} !== 3'b000 || IF_PC !== 32'h8000_0000 || Addr_I !== 29'h0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b en=%b irq=%b pc=%h addr=%h, want 0 0 0 80000000 00000000",
                     IF_Valid, En_I, IF_Irq, IF_PC, Addr_I);
        end
        sb.delete();
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        checks++;
        if ({En_I, IF_Valid} !== 2'b10 || Addr_I !== 29'h0) begin
            errors++;
            $display("FAIL restart_fetch: got en=%b valid=%b addr=%h, want 1 0 00000000", En_I, IF_Valid, Addr_I);
        end
        sb.push_back('{valid: 1'b1, irq: 1'b0, pc: 32'h8000_0000});
        @(negedge Clock);
        #1;
        e = sb.pop_front();
        checks++;
        if ({IF_Valid, IF_Irq, IF_PC} !== {e.valid, e.irq, e.pc} || IF_Instr !== {3'b000, e.pc[30:2]}) begin
            errors++;
            $display("FAIL restart_slot: got v=%b irq=%b pc=%h instr=%h, want v=%b irq=%b pc=%h instr=%h",
                     IF_Valid, IF_Irq, IF_PC, IF_Instr, e.valid, e.irq, e.pc, {3'b000, e.pc[30:2]});
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_illop_priority();
        test_irq();
        test_wrap();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
